// File: rtl/quad_signal_gen_if.sv
// Control/status bundle for the quadrature signal generator.
// The master drives run commands; the slave (generator) returns channels and status.
interface quad_signal_gen_if #(
   parameter int PERIOD_W = 16,
   parameter int COUNT_W  = 16
);
   logic                Start;
   logic                Stop;
   logic                Dir;
   logic [PERIOD_W-1:0] EdgePeriod;
   logic [COUNT_W-1:0]  EdgeCount;
   logic                ChannelA;
   logic                ChannelB;
   logic                Busy;
   logic                Done;
   logic [COUNT_W-1:0]  EdgesSent;

   modport master (
      output Start, Stop, Dir, EdgePeriod, EdgeCount,
      input  ChannelA, ChannelB, Busy, Done, EdgesSent
   );

   modport slave (
      input  Start, Stop, Dir, EdgePeriod, EdgeCount,
      output ChannelA, ChannelB, Busy, Done, EdgesSent
   );
endinterface

// File: rtl/quad_signal_gen.sv
// Quadrature A/B waveform generator: emits edges at a latched period and direction,
// for a programmed edge count or continuously until Stop.
module quad_signal_gen #(
   parameter int PERIOD_W = 16,
   parameter int COUNT_W  = 16
) (
   input logic               clk,
   input logic               reset_n,
   quad_signal_gen_if.slave  bus_io
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Shorter periods would let the 3-stage synchronized decoder miss edges.
   localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(4);

   state_e              state_q;
   logic [1:0]          phase_q;
   logic                dir_q;
   logic [PERIOD_W-1:0] period_q;
   logic [PERIOD_W-1:0] timer_q;
   logic [COUNT_W-1:0]  count_q;
   logic [COUNT_W-1:0]  edges_q;
   logic                busy_q;
   logic                done_q;

   logic [PERIOD_W-1:0] eff_period_s;
   logic [1:0]          phase_next_s;
   logic [COUNT_W-1:0]  edges_next_s;
   logic                last_edge_s;

   // One Gray step: exactly one channel toggles per call.
   function automatic logic [1:0] phase_step(input logic [1:0] ph, input logic dir);
      logic [1:0] nxt;
      if (dir == 1'b0) begin
         nxt = {ph[0], ~ph[1]};
      end else begin
         nxt = {~ph[0], ph[1]};
      end
      return nxt;
   endfunction

   // Clamped period, next phase/edge count and finite-run termination test.
   always_comb begin
      if (bus_io.EdgePeriod < MIN_PERIOD) begin
         eff_period_s = MIN_PERIOD;
      end else begin
         eff_period_s = bus_io.EdgePeriod;
      end
      phase_next_s = phase_step(phase_q, dir_q);
      edges_next_s = edges_q + COUNT_W'(1);
      last_edge_s  = (count_q != {COUNT_W{1'b0}}) && (edges_next_s == count_q);
   end

   // Run-control FSM with edge timer, phase register and status flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         phase_q  <= 2'b00;
         dir_q    <= 1'b0;
         period_q <= {PERIOD_W{1'b0}};
         timer_q  <= {PERIOD_W{1'b0}};
         count_q  <= {COUNT_W{1'b0}};
         edges_q  <= {COUNT_W{1'b0}};
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus_io.Start && !bus_io.Stop) begin
                  dir_q    <= bus_io.Dir;
                  period_q <= eff_period_s;
                  count_q  <= bus_io.EdgeCount;
                  edges_q  <= {COUNT_W{1'b0}};
                  timer_q  <= eff_period_s - PERIOD_W'(1);
                  busy_q   <= 1'b1;
                  state_q  <= RUN;
               end else begin
                  busy_q <= 1'b0;
               end
            end
            RUN: begin
               // Stop wins over an expiring timer: no edge on the abort cycle.
               if (bus_io.Stop) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end else if (timer_q == {PERIOD_W{1'b0}}) begin
                  phase_q <= phase_next_s;
                  edges_q <= edges_next_s;
                  timer_q <= period_q - PERIOD_W'(1);
                  if (last_edge_s) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     busy_q <= 1'b1;
                  end
               end else begin
                  timer_q <= timer_q - PERIOD_W'(1);
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus_io.ChannelA  = phase_q[1];
   assign bus_io.ChannelB  = phase_q[0];
   assign bus_io.Busy      = busy_q;
   assign bus_io.Done      = done_q;
   assign bus_io.EdgesSent = edges_q;

endmodule
